// File: rtl/tick_gen_decade.sv
// Decade-stepped tick generator: base strobe every DIVIDER*10^step cycles plus a
// cascade of decade channels; step advances on toggle edges, only at base wraps.
module tick_gen_decade #(
  parameter int unsigned DIVIDER            = 50,
  parameter int unsigned FREQ_DIGITS_STEP_N = 3,
  parameter int unsigned CHANNELS           = 3,
  localparam int unsigned STEP_W = (FREQ_DIGITS_STEP_N > 0) ? $clog2(FREQ_DIGITS_STEP_N + 1) : 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                toggle_i,
  output logic [CHANNELS-1:0] tick_o,
  output logic [STEP_W-1:0]   step_o
);

  function automatic longint unsigned period_of(int unsigned s);
    longint unsigned p;
    p = 64'(DIVIDER);
    for (int unsigned i = 0; i < s; i++) p = p * 10;
    return p;
  endfunction

  localparam int unsigned     N_SAFE = (FREQ_DIGITS_STEP_N > 9) ? 9 : FREQ_DIGITS_STEP_N;
  localparam longint unsigned MAX_P  = period_of(N_SAFE);
  localparam int unsigned     CNT_W  = $clog2(MAX_P);
  localparam int unsigned     TBL_N  = 1 << STEP_W;
  localparam int unsigned     DEC_N  = (CHANNELS > 1) ? CHANNELS - 1 : 1;

  if (DIVIDER < 2) begin : g_bad_divider
    $error("tick_gen_decade: DIVIDER must be at least 2");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("tick_gen_decade: CHANNELS must be at least 1");
  end
  if (FREQ_DIGITS_STEP_N > 9 || MAX_P > 64'hFFFF_FFFF) begin : g_bad_period
    $error("tick_gen_decade: DIVIDER * 10^FREQ_DIGITS_STEP_N must fit in 32 bits");
  end

  // Terminal count per step; unused step codes fall back to the base period.
  logic [CNT_W-1:0] last_tbl [TBL_N];
  for (genvar s = 0; s < TBL_N; s++) begin : g_tbl
    localparam longint unsigned PS = (s <= FREQ_DIGITS_STEP_N) ? period_of(s) : 64'(DIVIDER);
    assign last_tbl[s] = CNT_W'(PS - 1);
  end

  logic [CNT_W-1:0]    cnt_r;
  logic [STEP_W-1:0]   step_r;
  logic                pend_r;
  logic                tog_q_r;
  logic [3:0]          dec_r [DEC_N];
  logic [CHANNELS-1:0] carry;
  logic                tog_edge;
  logic                wrap;
  logic                advance;

  assign tog_edge = toggle_i & ~tog_q_r;
  assign wrap     = enable_i & (cnt_r == last_tbl[step_r]);
  assign advance  = wrap & (pend_r | tog_edge);
  assign step_o   = step_r;

  // carry[k]: decade channels 1..k all sit at 9 (carry[0] is the base wrap itself).
  always_comb begin
    logic run;
    run   = 1'b1;
    carry = '0;
    carry[0] = 1'b1;
    for (int unsigned k = 1; k < CHANNELS; k++) begin
      run      = run & (dec_r[k-1] == 4'd9);
      carry[k] = run;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r   <= '0;
      step_r  <= '0;
      pend_r  <= 1'b0;
      tog_q_r <= 1'b0;
      tick_o  <= '0;
      for (int unsigned i = 0; i < DEC_N; i++) dec_r[i] <= '0;
    end else begin
      tog_q_r <= toggle_i;
      tick_o  <= '0;

      if (advance)       pend_r <= 1'b0;
      else if (tog_edge) pend_r <= 1'b1;

      if (enable_i) cnt_r <= wrap ? '0 : cnt_r + CNT_W'(1);

      if (wrap) begin
        tick_o[0] <= 1'b1;
        if (advance) begin
          step_r <= (step_r == STEP_W'(FREQ_DIGITS_STEP_N)) ? '0 : step_r + STEP_W'(1);
          for (int unsigned i = 0; i < DEC_N; i++) dec_r[i] <= '0;
        end else begin
          for (int unsigned k = 1; k < CHANNELS; k++) begin
            tick_o[k] <= carry[k];
            if (carry[k-1]) dec_r[k-1] <= (dec_r[k-1] == 4'd9) ? 4'd0 : dec_r[k-1] + 4'd1;
          end
        end
      end
    end
  end

endmodule
